sram_port_ctrl: RTL
===================

Name: sram_port_ctrl

Overview:
- Request-side controller sitting directly upstream of the single-port SRAM macro models (CLK/CEB/WEB/A/D/Q, active-low enables, Q registered one cycle after a read).
- Accepts independent valid/ready write and read request channels and arbitrates them onto the one macro port.
- Captures macro Q in the single cycle it is valid and returns it through a back-pressured response channel.

Parameters:
BITS, 261, data width; equals macro Bits
DEPTH, 4, number of words; equals macro Word_Depth
AW, 2, address width; equals macro Add_Width (clog2 DEPTH)

Ports:
CLK  input  1  clock; shared with macro
RST_N  input  1  asynchronous active-low reset
wr_valid  input  1  write request valid
wr_ready  output  1  write request accepted this cycle
wr_addr  input  AW  write address
wr_data  input  BITS  write data
rd_valid  input  1  read request valid
rd_ready  output  1  read request accepted this cycle
rd_addr  input  AW  read address
resp_valid  output  1  read data valid
resp_ready  input  1  consumer takes read data
resp_data  output  BITS  read data
init_done  output  1  controller accepting requests
sram_CEB  output  1  macro chip enable, active low
sram_WEB  output  1  macro write enable, active low (0 = write)
sram_A  output  AW  macro address
sram_D  output  BITS  macro write data
sram_Q  input  BITS  macro read data

Behaviour:
- One clock CLK; reset asynchronous, active-low on RST_N. While RST_N=0: wr_ready=0, rd_ready=0, resp_valid=0, sram_CEB=1, sram_WEB=1, sram_A=0, sram_D=0, response FIFO empty, in-flight flag cleared.
- Single macro op per cycle. Macro pins are driven combinationally from the granted request in the cycle the handshake completes. Idle cycle: CEB=1, WEB=1, A=0, D=0; no X is ever driven.
- Arbitration: only one valid -> it is eligible. Both valid and read eligible -> alternate; flag last_win toggles on each conflict, and the first conflict after reset goes to write. The loser's ready=0.
- Read eligibility: fifo_cnt + rd_inflight - (resp_valid & resp_ready) < 2. The combinational path from resp_ready to rd_ready and sram_CEB is permitted.
- Write accepted (wr_valid & wr_ready): CEB=0, WEB=0, A=wr_addr, D=wr_data.
- Read accepted at cycle T: CEB=0, WEB=1, A=rd_addr. rd_inflight=1 during T+1. sram_Q is sampled at the end of T+1 into a 2-entry response FIFO. resp_valid is first high at T+2. Full-rate throughput holds when resp_ready is held high.
- Response FIFO: in-order; data is held stable while resp_valid & !resp_ready. Push and pop in the same cycle keep the count unchanged. Overflow is impossible by construction; the bench asserts this.
- Read at T+1 of a write at T to the same address returns the new data.
- FSM states INIT, RUN. INIT is entered only with SRAM_INIT_EN; otherwise reset goes straight to RUN. init_done = (state == RUN).
- Reset asserted mid-operation: in-flight read discarded, FIFO cleared, FSM returns to its reset state.

Optional Feature:
- Macro SRAM_INIT_EN.
- Defined: after RST_N deasserts, the FSM sits in INIT and writes zero to addresses 0..DEPTH-1, one per cycle, ascending (CEB=0, WEB=0, D=0). Both readies stay 0 throughout. It enters RUN after the write to DEPTH-1; init_done rises DEPTH cycles after reset release.
- Undefined: RUN from the first cycle after reset; init_done=1; memory contents undefined until written.

Decomposition:
- Package sram_ctrl_pkg: state enum {INIT, RUN}, grant enum {GNT_NONE, GNT_WR, GNT_RD}, constant RESP_DEPTH=2.
- Sub-module sram_resp_fifo: 2-entry, parameterised BITS, valid/ready pop side, push strobe plus count output.

Test Plan:
- Reset release with SRAM_INIT_EN, DEPTH=4 -> init_done rises exactly 4 cycles later; reading addr 0..3 then returns all zeros.
- Write addr 2 = 0x1 at T, read addr 2 at T+1, resp_ready=1 -> resp_valid and resp_data=0x1 at T+3.
- wr_valid and rd_valid held high together for 4 cycles, FIFO empty -> grants alternate W, R, W, R; 2 responses returned.
- resp_ready=0, 3 reads requested back-to-back -> 2 accepted, third rd_ready=0. Raise resp_ready -> third accepted in the same cycle as the first pop; data returned in order.
- RST_N pulsed low the cycle after a read is accepted -> no resp_valid follows, sram_CEB=1 during reset, FIFO empty after release.
- Idle 10 cycles, no requests -> sram_CEB=1, WEB=1, A=0, D=0 every cycle.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM port controller slice.
package sram_ctrl_pkg;

    typedef enum logic {INIT, RUN} state_t;

    typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} gnt_t;

    localparam int unsigned RESP_DEPTH = 2;

endpackage

// File: rtl/sram_resp_fifo.sv
// Two-entry in-order response buffer: push strobe in, valid/ready out, occupancy count.
module sram_resp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned BITS = 261
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            push,
    input  logic [BITS-1:0] push_data,
    output logic            valid,
    input  logic            ready,
    output logic [BITS-1:0] data,
    output logic [1:0]      count
);

    logic [BITS-1:0] mem [RESP_DEPTH];
    logic            wptr;
    logic            rptr;
    logic            pop;

    assign pop   = valid & ready;
    assign valid = (count != 2'd0);
    assign data  = mem[rptr];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem   <= '{default: '0};
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_port_ctrl.sv
// Arbitrates write/read request channels onto one single-port SRAM macro port.
// Build option: SRAM_INIT_EN zero-fills the macro after reset before accepting requests.
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned BITS  = 261,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [AW-1:0]   wr_addr,
    input  logic [BITS-1:0] wr_data,
    input  logic            rd_valid,
    output logic            rd_ready,
    input  logic [AW-1:0]   rd_addr,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [BITS-1:0] resp_data,
    output logic            init_done,
    output logic            sram_CEB,
    output logic            sram_WEB,
    output logic [AW-1:0]   sram_A,
    output logic [BITS-1:0] sram_D,
    input  logic [BITS-1:0] sram_Q
);

`ifdef SRAM_INIT_EN
    localparam state_t RST_STATE = INIT;
    logic [AW-1:0] init_addr;
`else
    localparam state_t RST_STATE = RUN;
`endif

    state_t     state;
    gnt_t       gnt;
    gnt_t       last_win;
    logic       rd_inflight;
    logic [1:0] fifo_cnt;
    logic       run;
    logic       pop;
    logic [2:0] rd_load;
    logic       rd_elig;
    logic       conflict;

    // Gating with RST_N keeps readies and macro pins quiet while reset is held.
    assign run       = RST_N && (state == RUN);
    assign init_done = (state == RUN);
    assign pop       = resp_valid & resp_ready;
    assign rd_load   = {1'b0, fifo_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
    assign rd_elig   = (rd_load < 3'd2);
    assign conflict  = run && wr_valid && rd_valid && rd_elig;

    always_comb begin
        gnt = GNT_NONE;
        if (conflict) begin
            gnt = (last_win == GNT_WR) ? GNT_RD : GNT_WR;
        end else if (run && wr_valid) begin
            gnt = GNT_WR;
        end else if (run && rd_valid && rd_elig) begin
            gnt = GNT_RD;
        end
    end

    assign wr_ready = (gnt == GNT_WR);
    assign rd_ready = (gnt == GNT_RD);

    always_comb begin
        sram_CEB = 1'b1;
        sram_WEB = 1'b1;
        sram_A   = '0;
        sram_D   = '0;
`ifdef SRAM_INIT_EN
        if (RST_N && (state == INIT)) begin
            sram_CEB = 1'b0;
            sram_WEB = 1'b0;
            sram_A   = init_addr;
        end
`endif
        case (gnt)
            GNT_WR: begin
                sram_CEB = 1'b0;
                sram_WEB = 1'b0;
                sram_A   = wr_addr;
                sram_D   = wr_data;
            end
            GNT_RD: begin
                sram_CEB = 1'b0;
                sram_A   = rd_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= RST_STATE;
            last_win    <= GNT_RD;
            rd_inflight <= 1'b0;
`ifdef SRAM_INIT_EN
            init_addr   <= '0;
`endif
        end else begin
            rd_inflight <= (gnt == GNT_RD);
            if (conflict) begin
                last_win <= gnt;
            end
`ifdef SRAM_INIT_EN
            if (state == INIT) begin
                init_addr <= init_addr + 1'b1;
                if (init_addr == AW'(DEPTH - 1)) begin
                    state <= RUN;
                end
            end
`endif
        end
    end

    sram_resp_fifo #(
        .BITS (BITS)
    ) u_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (rd_inflight),
        .push_data (sram_Q),
        .valid     (resp_valid),
        .ready     (resp_ready),
        .data      (resp_data),
        .count     (fifo_cnt)
    );

endmodule
